// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front-end.
//   br_type_t     : branch/jump kind, encoded to match funct3
//   fetch_entry_t : queue payload, fetched instruction tagged with its PC
//   CNT_W         : width of occupancy/credit counters for the default depth
package fetch_pkg;

    localparam int unsigned FETCH_XLEN  = 32;
    localparam int unsigned FETCH_DEPTH = 4;
    localparam int unsigned CNT_W       = $clog2(FETCH_DEPTH) + 1;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        JAL  = 3'b010,
        JALR = 3'b011,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_type_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_redirect_unit_fifo.sv
// fetch_fifo: synchronous DEPTH-entry queue of fetch_entry_t.
//   push/wr_data : enqueue one entry
//   pop          : dequeue head (ignored when empty)
//   flush        : empty the queue; overrides a same-cycle push or pop
//   rd_data      : current head entry
//   count        : occupancy
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wr_data,
    output fetch_entry_t             rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && (count != '0) && !flush;

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign rd_data = mem[rd_ptr];

    // Credit-based issue upstream must never overfill the queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (!n_rst)
        (push && !pop && !flush) |-> (count < CW'(DEPTH)));

endmodule

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: in-order instruction fetch with up to DEPTH requests in
// flight, a PC-tagged response queue, and branch/jump resolution from execute.
//   imem_req_*  : request channel to instruction memory (address = fetch PC)
//   imem_rsp_*  : in-order responses from instruction memory
//   instr_*     : queue head towards decode (valid/ready handshake)
//   ex_*        : branch/jump operands from the execute stage
//   redirect, redirect_pc, misalign : combinational resolution results
module fetch_redirect_unit
    import fetch_pkg::*;
#(
    parameter int unsigned    XLEN     = FETCH_XLEN,
    parameter int unsigned    DEPTH    = FETCH_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             n_rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr_data,
    output logic [XLEN-1:0]  instr_pc,
    input  logic             ex_valid,
    input  logic [2:0]       ex_br_type,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_imm,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             misalign
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   count;
    logic            started;

    logic            req_fire;
    logic            rsp_drop;
    logic            rsp_push;
    logic [CW-1:0]   inflight_next;
    logic            cond;
    logic            taken;
    logic [XLEN-1:0] target;

    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    // Branch condition and target resolution.
    always_comb begin
        cond   = 1'b0;
        target = ex_pc + ex_imm;
        case (br_type_t'(ex_br_type))
            BEQ:  cond = (ex_rs1 == ex_rs2);
            BNE:  cond = (ex_rs1 != ex_rs2);
            BLT:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
            BGE:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
            BLTU: cond = (ex_rs1 <  ex_rs2);
            BGEU: cond = (ex_rs1 >= ex_rs2);
            JAL:  cond = 1'b1;
            JALR: begin
                cond   = 1'b1;
                target = (ex_rs1 + ex_imm) & ~XLEN'(1);
            end
            default: cond = 1'b0;
        endcase
    end

    assign taken       = ex_valid && cond;
    assign misalign    = taken && target[1];
    assign redirect    = taken && !target[1];
    assign redirect_pc = target;

    // Queue slots plus in-flight requests form the credit pool.
    assign imem_req_valid = started &&
                            (({1'b0, count} + {1'b0, outstanding}) < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fpc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses to requests issued before a redirect are dropped.
    assign rsp_drop      = (discard != '0);
    assign rsp_push      = imem_rsp_valid && !rsp_drop;
    assign inflight_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fpc         <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            started     <= 1'b0;
        end else begin
            started     <= 1'b1;
            outstanding <= inflight_next;
            if (redirect) begin
                // Everything still in flight after this edge belongs to the old path.
                fpc     <= target;
                rsp_pc  <= target;
                discard <= inflight_next;
            end else begin
                if (req_fire) begin
                    fpc <= fpc + XLEN'(4);
                end
                if (rsp_push) begin
                    rsp_pc <= rsp_pc + XLEN'(4);
                end
                if (imem_rsp_valid && rsp_drop) begin
                    discard <= discard - CW'(1);
                end
            end
        end
    end

    assign wr_entry.pc    = FETCH_XLEN'(rsp_pc);
    assign wr_entry.instr = imem_rsp_data;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .push    (rsp_push),
        .pop     (instr_ready),
        .flush   (redirect),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (count)
    );

    assign instr_valid = (count != '0);
    assign instr_data  = head.instr;
    assign instr_pc    = XLEN'(head.pc);

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Testbench for fetch_redirect_unit: behavioural instruction memory with
// 1-cycle in-order responses, and a queue of expected PCs consumed as decode
// pops instructions.
module tb_fetch_redirect_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        n_rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        ex_valid;
    logic [2:0]  ex_br_type;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [31:0] ex_imm;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misalign;

    fetch_redirect_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .ex_valid       (ex_valid),
        .ex_br_type     (ex_br_type),
        .ex_pc          (ex_pc),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_imm         (ex_imm),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .misalign       (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_chk;
    int               n_err;
    logic [31:0]      exp_q[$];
    logic [31:0]      mem_q[$];
    logic [CNT_W-1:0] fire_cnt;
    logic             rsp_en;
    logic             sink;
    logic             exp_redirect;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Instruction memory: accept on the edge, answer one cycle later, in order.
    initial begin : imem_model
        logic        fire;
        logic        took;
        logic [31:0] a;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #2;
            fire = n_rst && imem_req_valid && imem_req_ready;
            a    = imem_req_addr;
            took = imem_rsp_valid;
            @(posedge clk);
            #1;
            if (!n_rst) begin
                mem_q.delete();
            end else begin
                if (took && mem_q.size() != 0) void'(mem_q.pop_front());
                if (fire) mem_q.push_back(a);
            end
            if (mem_q.size() != 0 && rsp_en) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_data(mem_q[0]);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    // One clock: observe handshakes before the edge, return on the next negedge.
    task automatic step();
        logic [31:0] e;
        #1;
        if (imem_req_valid && imem_req_ready) fire_cnt = fire_cnt + CNT_W'(1);
        if (instr_valid && instr_ready && !exp_redirect && !sink && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("instr_pc", instr_pc, e);
            chk("instr_data", instr_data, mem_data(e));
        end
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            instr_ready = 1'b1;
            step();
            n++;
        end
        instr_ready = 1'b0;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_ex(input logic v, input logic [2:0] t, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        ex_valid   = v;
        ex_br_type = t;
        ex_pc      = pc;
        ex_rs1     = a;
        ex_rs2     = b;
        ex_imm     = imm;
    endtask

    logic [2:0]  t_tab [7];
    logic [31:0] a_tab [7];
    logic [31:0] b_tab [7];
    logic        e_tab [7];

    initial begin
        n_chk = 0;
        n_err = 0;
        fire_cnt = '0;
        rsp_en = 1'b1;
        sink = 1'b0;
        exp_redirect = 1'b0;
        n_rst = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready = 1'b0;
        set_ex(1'b0, BEQ, '0, '0, '0, '0);

        t_tab = '{BNE, BNE, BGE, BGEU, BEQ, BGE, BLTU};
        a_tab = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd1, 32'd1};
        b_tab = '{32'd5, 32'd6, 32'd1, 32'd1, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        e_tab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_data", instr_data, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        n_rst = 1'b1;
        #1;
        chk("pre_start_req_valid", 32'(imem_req_valid), 32'd0);

        // Fill with decode stalled: exactly DEPTH requests, then stop.
        fire_cnt = '0;
        repeat (12) step();
        chk("fill_fires", 32'(fire_cnt), 32'd4);
        chk("fill_req_valid", 32'(imem_req_valid), 32'd0);
        chk("fill_instr_valid", 32'(instr_valid), 32'd1);
        push_exp(32'h0, 8);
        drain(40);

        // BLTU with these operands is not taken.
        set_ex(1'b1, BLTU, 32'h20, 32'hFFFF_FFFF, 32'd1, 32'h40);
        #1;
        chk("bltu_redirect", 32'(redirect), 32'd0);
        step();
        set_ex(1'b0, BEQ, '0, '0, '0, '0);
        push_exp(32'h20, 2);
        drain(20);

        // BLT signed: -1 < 1, taken to 0x60.
        set_ex(1'b1, BLT, 32'h20, 32'hFFFF_FFFF, 32'd1, 32'h40);
        exp_redirect = 1'b1;
        #1;
        chk("blt_redirect", 32'(redirect), 32'd1);
        chk("blt_target", redirect_pc, 32'h60);
        chk("blt_misalign", 32'(misalign), 32'd0);
        step();
        exp_redirect = 1'b0;
        set_ex(1'b0, BEQ, '0, '0, '0, '0);
        chk("flush_empty", 32'(instr_valid), 32'd0);
        push_exp(32'h60, 4);
        drain(30);

        // Empty the pipe, then leave exactly two requests unanswered.
        imem_req_ready = 1'b0;
        sink = 1'b1;
        instr_ready = 1'b1;
        repeat (10) step();
        instr_ready = 1'b0;
        sink = 1'b0;
        chk("sink_empty", 32'(instr_valid), 32'd0);
        rsp_en = 1'b0;
        fire_cnt = '0;
        imem_req_ready = 1'b1;
        step();
        step();
        imem_req_ready = 1'b0;
        chk("two_outstanding", 32'(fire_cnt), 32'd2);

        // JALR drops both stale responses.
        set_ex(1'b1, JALR, 32'h80, 32'h101, 32'd0, 32'h10);
        exp_redirect = 1'b1;
        #1;
        chk("jalr_redirect", 32'(redirect), 32'd1);
        chk("jalr_target", redirect_pc, 32'h110);
        step();
        exp_redirect = 1'b0;
        set_ex(1'b0, BEQ, '0, '0, '0, '0);
        rsp_en = 1'b1;
        imem_req_ready = 1'b1;
        push_exp(32'h110, 4);
        drain(40);

        // Misaligned JAL target: flagged, sequential stream unaffected.
        push_exp(32'h120, 4);
        set_ex(1'b1, JAL, 32'h0, 32'd0, 32'd0, 32'h6);
        #1;
        chk("jal_misalign", 32'(misalign), 32'd1);
        chk("jal_redirect", 32'(redirect), 32'd0);
        instr_ready = 1'b1;
        step();
        set_ex(1'b0, BEQ, '0, '0, '0, '0);
        drain(30);

        // Redirect coinciding with a request fire and a response arrival.
        push_exp(32'h130, 4);
        begin
            int n;
            n = 0;
            while (exp_q.size() > 1 && n < 30) begin
                instr_ready = 1'b1;
                step();
                n++;
            end
        end
        exp_q.delete();
        push_exp(32'h300, 8);
        set_ex(1'b1, BEQ, 32'h200, 32'd7, 32'd7, 32'h100);
        exp_redirect = 1'b1;
        instr_ready = 1'b1;
        #1;
        chk("collide_fire_rsp", 32'(imem_req_valid && imem_req_ready && imem_rsp_valid), 32'd1);
        chk("beq_redirect", 32'(redirect), 32'd1);
        chk("beq_target", redirect_pc, 32'h300);
        step();
        exp_redirect = 1'b0;
        set_ex(1'b0, BEQ, '0, '0, '0, '0);
        drain(60);

        // Remaining conditions, resolution only.
        for (int i = 0; i < 7; i++) begin
            set_ex(1'b1, t_tab[i], 32'h400, a_tab[i], b_tab[i], 32'h10);
            #1;
            chk($sformatf("cond_%0d_redirect", i), 32'(redirect), 32'(e_tab[i]));
            if (e_tab[i]) chk($sformatf("cond_%0d_target", i), redirect_pc, 32'h410);
            step();
            set_ex(1'b0, BEQ, '0, '0, '0, '0);
            step();
        end
        set_ex(1'b0, JAL, 32'h400, 32'd0, 32'd0, 32'h10);
        #1;
        chk("no_ex_valid", 32'(redirect), 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
